// File: rtl/program_loader.sv
// Byte-stream program loader: assembles 16-bit words (high byte first) and writes them to memory
// while holding the CPU in reset. Optional trailing checksum enabled by LOADER_CHECKSUM_EN.
module program_loader #(
   parameter logic [15:0] BASE_ADDR = 16'h0000,
   parameter int          MAX_WORDS = 1024
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic [15:0] mem_address,
   output logic [15:0] mem_data,
   output logic        mem_write,
   output logic        cpu_hold,
   output logic        busy,
   output logic        done,
   output logic        error
);

   typedef enum logic [3:0] {
      IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, DONE, ERROR
`ifdef LOADER_CHECKSUM_EN
      , CSUM_HI, CSUM_LO
`endif
   } state_t;

   localparam logic [16:0] MaxWordsL = 17'(MAX_WORDS);

   state_t      r_state;
   state_t      w_nextState;
   state_t      w_tailState;
   logic        w_accept;
   logic        w_accepting;
   logic        w_busy;
   logic [15:0] w_countWord;
   logic [7:0]  r_countHi;
   logic [15:0] r_remaining;
   logic [7:0]  r_wordHi;
   logic [15:0] r_memAddress;
   logic [15:0] r_memData;
   logic        r_rxReady;
   logic        r_memWrite;
   logic        r_cpuHold;
   logic        r_busy;
   logic        r_done;
   logic        r_error;
`ifdef LOADER_CHECKSUM_EN
   logic [15:0] r_sum;
   logic [7:0]  r_csumHi;
`endif

   assign w_accept    = rx_valid & r_rxReady;
   assign w_countWord = {r_countHi, rx_data};

   // After the last word (or an empty image) either verify a checksum or finish directly.
`ifdef LOADER_CHECKSUM_EN
   assign w_tailState = CSUM_HI;
`else
   assign w_tailState = DONE;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_nextState;
   end

   always_comb begin
      w_nextState = r_state;
      unique case (r_state)
         IDLE, DONE, ERROR: if (start) w_nextState = LEN_HI;
         LEN_HI:  if (w_accept) w_nextState = LEN_LO;
         LEN_LO: begin
            if (w_accept) begin
               if (w_countWord == 16'd0)                    w_nextState = w_tailState;
               else if ({1'b0, w_countWord} > MaxWordsL)    w_nextState = ERROR;
               else                                         w_nextState = DATA_HI;
            end
         end
         DATA_HI: if (w_accept) w_nextState = DATA_LO;
         DATA_LO: if (w_accept) w_nextState = WRITE;
         WRITE:   w_nextState = (r_remaining == 16'd1) ? w_tailState : DATA_HI;
`ifdef LOADER_CHECKSUM_EN
         CSUM_HI: if (w_accept) w_nextState = CSUM_LO;
         CSUM_LO: if (w_accept) w_nextState = ({r_csumHi, rx_data} == r_sum) ? DONE : ERROR;
`endif
         default: w_nextState = IDLE;
      endcase
   end

   always_comb begin
      w_accepting = 1'b0;
      w_busy      = 1'b0;
      unique case (w_nextState)
         LEN_HI, LEN_LO, DATA_HI, DATA_LO: begin
            w_accepting = 1'b1;
            w_busy      = 1'b1;
         end
         WRITE: w_busy = 1'b1;
`ifdef LOADER_CHECKSUM_EN
         CSUM_HI, CSUM_LO: begin
            w_accepting = 1'b1;
            w_busy      = 1'b1;
         end
`endif
         default: begin
            w_accepting = 1'b0;
            w_busy      = 1'b0;
         end
      endcase
   end

   // Status outputs are registered from the next state so they line up with the state register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_rxReady  <= 1'b0;
         r_memWrite <= 1'b0;
         r_cpuHold  <= 1'b1;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_error    <= 1'b0;
      end else begin
         r_rxReady  <= w_accepting;
         r_memWrite <= (w_nextState == WRITE);
         r_cpuHold  <= (w_nextState != DONE);
         r_busy     <= w_busy;
         r_done     <= (w_nextState == DONE);
         r_error    <= (w_nextState == ERROR);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_countHi    <= 8'd0;
         r_remaining  <= 16'd0;
         r_wordHi     <= 8'd0;
         r_memAddress <= 16'd0;
         r_memData    <= 16'd0;
`ifdef LOADER_CHECKSUM_EN
         r_sum        <= 16'd0;
         r_csumHi     <= 8'd0;
`endif
      end else begin
         unique case (r_state)
            IDLE, DONE, ERROR: begin
               if (start) begin
                  r_memAddress <= BASE_ADDR;
`ifdef LOADER_CHECKSUM_EN
                  r_sum        <= 16'd0;
`endif
               end
            end
            LEN_HI:  if (w_accept) r_countHi <= rx_data;
            LEN_LO:  if (w_accept) r_remaining <= w_countWord;
            DATA_HI: if (w_accept) r_wordHi <= rx_data;
            DATA_LO: if (w_accept) r_memData <= {r_wordHi, rx_data};
            WRITE: begin
               r_memAddress <= r_memAddress + 16'd1;
               r_remaining  <= r_remaining - 16'd1;
`ifdef LOADER_CHECKSUM_EN
               r_sum        <= r_sum + r_memData;
`endif
            end
`ifdef LOADER_CHECKSUM_EN
            CSUM_HI: if (w_accept) r_csumHi <= rx_data;
            CSUM_LO: ;
`endif
            default: ;
         endcase
      end
   end

   assign rx_ready    = r_rxReady;
   assign mem_address = r_memAddress;
   assign mem_data    = r_memData;
   assign mem_write   = r_memWrite;
   assign cpu_hold    = r_cpuHold;
   assign busy        = r_busy;
   assign done        = r_done;
   assign error       = r_error;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: two instances (base 0x0000 and 0xFFFF) share one stream;
// expected writes and final status come from a queue-based model of the image format.
module tb_program_loader;

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic [7:0]  rxData;
   logic        rxValid;

   logic        aReady, aWrite, aHold, aBusy, aDone, aError;
   logic [15:0] aAddr, aData;
   logic        bReady, bWrite, bHold, bBusy, bDone, bError;
   logic [15:0] bAddr, bData;

   always #5 clock = ~clock;

   program_loader #(.BASE_ADDR(16'h0000), .MAX_WORDS(1024)) dutA (
      .clock(clock), .reset(reset), .start(start), .rx_data(rxData), .rx_valid(rxValid),
      .rx_ready(aReady), .mem_address(aAddr), .mem_data(aData), .mem_write(aWrite),
      .cpu_hold(aHold), .busy(aBusy), .done(aDone), .error(aError)
   );

   program_loader #(.BASE_ADDR(16'hFFFF), .MAX_WORDS(1024)) dutB (
      .clock(clock), .reset(reset), .start(start), .rx_data(rxData), .rx_valid(rxValid),
      .rx_ready(bReady), .mem_address(bAddr), .mem_data(bData), .mem_write(bWrite),
      .cpu_hold(bHold), .busy(bBusy), .done(bDone), .error(bError)
   );

   typedef struct {
      logic [15:0] addrA;
      logic [15:0] addrB;
      logic [15:0] data;
   } write_t;

   write_t      expQ[$];
   logic [7:0]  byteQ[$];
   write_t      monW;
   int          passCount  = 0;
   int          checkCount = 0;
   int          writesSeen = 0;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed === expected) passCount++;
      else $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
   endtask

   task automatic expectWrite(input int idx, input logic [15:0] data);
      write_t w;
      w.addrA = 16'(16'h0000 + idx);
      w.addrB = 16'(16'hFFFF + idx);
      w.data  = data;
      expQ.push_back(w);
   endtask

   // Scoreboard: every write strobe must match the next modelled write on both instances.
   always @(negedge clock) begin
      if (aWrite || bWrite) begin
         writesSeen++;
         checkOutput("writeLockstep", 32'(bWrite), 32'(aWrite));
         checkOutput("readyInWrite", 32'(aReady), 32'd0);
         if (expQ.size() == 0) begin
            checkOutput("unexpectedWrite", 32'd1, 32'd0);
         end else begin
            monW = expQ.pop_front();
            checkOutput("writeAddrA", 32'(aAddr), 32'(monW.addrA));
            checkOutput("writeAddrB", 32'(bAddr), 32'(monW.addrB));
            checkOutput("writeData", 32'(aData), 32'(monW.data));
         end
      end
   end

   task automatic buildLoad(input int count, input bit badCsum);
      logic [15:0] word;
      logic [15:0] sum;
      byteQ.delete();
      sum = 16'd0;
      byteQ.push_back(8'(count >> 8));
      byteQ.push_back(8'(count));
      if (count <= 1024) begin
         for (int i = 0; i < count; i++) begin
            word = 16'($urandom);
            sum  = sum + word;
            byteQ.push_back(word[15:8]);
            byteQ.push_back(word[7:0]);
            expectWrite(i, word);
         end
`ifdef LOADER_CHECKSUM_EN
         if (badCsum) sum = sum ^ 16'h0100;
         byteQ.push_back(sum[15:8]);
         byteQ.push_back(sum[7:0]);
`endif
      end
   endtask

   task automatic pulseStart();
      start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
   endtask

   task automatic sendByte(input logic [7:0] b, input int gapMax, input bit injectStart);
      int gap;
      bit got;
      gap = (gapMax > 0) ? int'($urandom_range(0, gapMax)) : 0;
      rxValid = 1'b0;
      for (int g = 0; g < gap; g++) begin
         start = injectStart && ($urandom_range(0, 1) == 0);
         @(posedge clock); #1;
         start = 1'b0;
      end
      rxData  = b;
      rxValid = 1'b1;
      got     = 1'b0;
      for (int t = 0; t < 50 && !got; t++) begin
         @(negedge clock);
         if (aReady) got = 1'b1;
         @(posedge clock); #1;
      end
      rxValid = 1'b0;
      if (!got) checkOutput("byteTimeout", 32'd0, 32'd1);
   endtask

   task automatic applyStimulus(input int gapMax, input bit injectStart);
      foreach (byteQ[i]) sendByte(byteQ[i], gapMax, injectStart);
   endtask

   task automatic runLoad(input int gapMax, input bit injectStart, input bit expectDone,
                          input int bound, input int nWrites);
      int base;
      pulseStart();
      base = writesSeen;
      applyStimulus(gapMax, injectStart);
      for (int t = 0; t < bound && !(aDone || aError); t++) begin
         @(posedge clock); #1;
      end
      checkOutput("done", 32'(aDone), 32'(expectDone));
      checkOutput("error", 32'(aError), 32'(!expectDone));
      checkOutput("cpuHold", 32'(aHold), 32'(!expectDone));
      checkOutput("busyAfter", 32'(aBusy), 32'd0);
      checkOutput("doneB", 32'(bDone), 32'(expectDone));
      checkOutput("writeCount", 32'(writesSeen - base), 32'(nWrites));
      checkOutput("pendingWrites", 32'(expQ.size()), 32'd0);
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "Hold"}, 32'(aHold), 32'd1);
      checkOutput({tag, "Busy"}, 32'(aBusy), 32'd0);
      checkOutput({tag, "Done"}, 32'(aDone), 32'd0);
      checkOutput({tag, "Error"}, 32'(aError), 32'd0);
      checkOutput({tag, "Ready"}, 32'(aReady), 32'd0);
      checkOutput({tag, "Write"}, 32'(aWrite), 32'd0);
      checkOutput({tag, "AddrA"}, 32'(aAddr), 32'd0);
      checkOutput({tag, "AddrB"}, 32'(bAddr), 32'd0);
      checkOutput({tag, "Data"}, 32'(aData), 32'd0);
   endtask

   initial begin
      int n;
      int base;
      reset = 1'b1; start = 1'b0; rxValid = 1'b0; rxData = 8'h00;
      repeat (3) @(posedge clock);
      #1;
      checkResetState("reset");
      reset = 1'b0;
      @(posedge clock); #1;

      byteQ = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h07};
`ifdef LOADER_CHECKSUM_EN
      byteQ.push_back(8'hBE);
      byteQ.push_back(8'h08);
`endif
      expectWrite(0, 16'h1234);
      expectWrite(1, 16'hABCD);
      expectWrite(2, 16'h0007);
      runLoad(0, 1'b0, 1'b1, 4, 3);

      byteQ = '{8'h00, 8'h00};
`ifdef LOADER_CHECKSUM_EN
      byteQ.push_back(8'h00);
      byteQ.push_back(8'h00);
`endif
      runLoad(0, 1'b0, 1'b1, 2, 0);

      buildLoad(16'h0401, 1'b0);
      runLoad(1, 1'b0, 1'b0, 3, 0);
      buildLoad(5, 1'b0);
      runLoad(2, 1'b0, 1'b1, 4, 5);

      for (int i = 0; i < 6; i++) begin
         n = int'($urandom_range(1, 8));
         buildLoad(n, 1'b0);
         runLoad(3, 1'b1, 1'b1, 6, n);
      end

      // Abort while the low data byte is pending; nothing may be written.
      buildLoad(2, 1'b0);
      expQ.delete();
      base = writesSeen;
      pulseStart();
      for (int i = 0; i < 3; i++) sendByte(byteQ[i], 0, 1'b0);
      rxData  = byteQ[3];
      rxValid = 1'b1;
      #1 reset = 1'b1;
      #1 checkResetState("midReset");
      @(posedge clock); #1;
      rxValid = 1'b0;
      reset   = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      checkOutput("midResetWrites", 32'(writesSeen - base), 32'd0);

`ifdef LOADER_CHECKSUM_EN
      buildLoad(3, 1'b1);
      runLoad(1, 1'b0, 1'b0, 4, 3);
`endif
      buildLoad(4, 1'b0);
      runLoad(1, 1'b0, 1'b1, 4, 4);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
